// File: rtl/udp_roce_tx_segmenter_64.sv
// udp_roce_tx_segmenter_64: splits one RDMA WRITE request into PMTU-sized RC packet descriptors
module udp_roce_tx_segmenter_64 #(
    parameter int PMTU_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_start_transfer,
    input  logic [31:0] s_dma_length,
    input  logic [31:0] s_r_key,
    input  logic [23:0] s_rem_qpn,
    input  logic [23:0] s_loc_psn,
    input  logic [31:0] s_rem_ip_addr,
    input  logic [63:0] s_rem_addr,
    input  logic        s_write_type,
    output logic        m_desc_valid,
    input  logic        m_desc_ready,
    output logic [7:0]  m_bth_opcode,
    output logic [23:0] m_bth_psn,
    output logic [23:0] m_bth_dest_qp,
    output logic [63:0] m_reth_vaddr,
    output logic [31:0] m_reth_r_key,
    output logic [31:0] m_reth_length,
    output logic [31:0] m_ip_dest_ip,
    output logic [15:0] m_payload_length,
    output logic        m_last_pkt,
    output logic        busy,
    output logic        done,
    output logic [23:0] next_psn
);
    localparam logic [31:0] PMTU = 32'd1 << PMTU_LOG2;
    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;
    state_t state, state_nx;
    logic start_q, start, fire, last, first, emit, wt_q;
    logic [31:0] rem_len, len_q, r_key_q, ip_q;
    logic [23:0] qpn_q, psn;
    logic [63:0] addr_q;
    assign start = s_start_transfer & ~start_q;
    assign emit  = state == EMIT;
    assign fire  = emit & m_desc_ready;
    // the final packet is the one whose remainder fits in a single PMTU (covers zero length too)
    assign last  = rem_len <= PMTU;
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    // next-state: starts only count in IDLE, so edges during a transfer are dropped
    always_comb begin
        state_nx = state == IDLE ? (start ? EMIT : IDLE) :
                   state == EMIT ? (fire && last ? DONE : EMIT) : IDLE;
    end
    // request latch, segmentation counters and edge detector
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q  <= 1'b0;
            first    <= 1'b0;
            wt_q     <= 1'b0;
            rem_len  <= '0;
            len_q    <= '0;
            r_key_q  <= '0;
            ip_q     <= '0;
            qpn_q    <= '0;
            psn      <= '0;
            addr_q   <= '0;
            next_psn <= '0;
        end else begin
            start_q <= s_start_transfer;
            if (state == IDLE && start) begin
                first   <= 1'b1;
                wt_q    <= s_write_type;
                rem_len <= s_dma_length;
                len_q   <= s_dma_length;
                r_key_q <= s_r_key;
                ip_q    <= s_rem_ip_addr;
                qpn_q   <= s_rem_qpn;
                psn     <= s_loc_psn;
                addr_q  <= s_rem_addr;
            end else if (fire) begin
                first   <= 1'b0;
                psn     <= psn + 24'd1;
                rem_len <= rem_len - PMTU;
                if (last) next_psn <= psn + 24'd1;
            end
        end
    end
    // descriptor outputs are driven only while emitting; status flags follow the state
    always_comb begin
        m_desc_valid     = emit;
        busy             = state != IDLE;
        done             = state == DONE;
        m_bth_opcode     = !emit ? 8'h00 :
                           first && last ? (wt_q ? 8'h0B : 8'h0A) :
                           first ? 8'h06 :
                           last ? (wt_q ? 8'h09 : 8'h08) : 8'h07;
        m_bth_psn        = emit ? psn : '0;
        m_bth_dest_qp    = emit ? qpn_q : '0;
        m_reth_vaddr     = emit ? addr_q : '0;
        m_reth_r_key     = emit ? r_key_q : '0;
        m_reth_length    = emit ? len_q : '0;
        m_ip_dest_ip     = emit ? ip_q : '0;
        m_payload_length = !emit ? 16'd0 : last ? rem_len[15:0] : PMTU[15:0];
        m_last_pkt       = emit & last;
    end
endmodule
